// File: rtl/ghost_pkg.sv
// Shared constants and types for the sprite movers and the maze wall probe.
// Holds screen/sprite/map geometry, the direction encoding used on every
// mover interface, the probe FSM state type and the probe offset helper.
package ghost_pkg;

  localparam int SPRITE     = 16;
  localparam int CELL_SHIFT = 2;
  localparam int SCR_W      = 640;
  localparam int SCR_H      = 480;
  localparam int MAP_W      = SCR_W >> CELL_SHIFT;
  localparam int ADDR_W     = 15;

  // Probes sit every cell along the leading edge, plus one on the last pixel.
  localparam int NPROBE = (SPRITE >> CELL_SHIFT) + 1;
  // Counter must also hold NPROBE itself ("all probes done").
  localparam int K_W    = $clog2(NPROBE + 1);

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BOUND,
    ST_ADDR,
    ST_READ
  } probe_state_e;

  // Pixel offset of probe k along the sprite's leading edge.
  function automatic logic [10:0] probe_off(input logic [K_W-1:0] k);
    if (k == K_W'(NPROBE - 1)) return 11'(SPRITE - 1);
    return 11'(k) << CELL_SHIFT;
  endfunction

endpackage

// File: rtl/maze_wall_probe_if.sv
// Mover-side probe handshake plus the wall-map read port of the probe block.
// slave  : the maze_wall_probe block (accepts requests, drives wall_addr)
// master : the mover / wall-map side (issues requests, returns wall_data)
interface maze_wall_probe_if;
  import ghost_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [9:0]        req_x;
  logic [8:0]        req_y;
  logic [1:0]        req_dir;
  logic              resp_valid;
  logic              resp_clear;
  logic [ADDR_W-1:0] wall_addr;
  logic              wall_data;

  modport slave (
    input  req_valid, req_x, req_y, req_dir, wall_data,
    output req_ready, resp_valid, resp_clear, wall_addr
  );

  modport master (
    output req_valid, req_x, req_y, req_dir, wall_data,
    input  req_ready, resp_valid, resp_clear, wall_addr
  );

endinterface

// File: rtl/maze_probe_addr.sv
// Combinational probe geometry: for a sprite at (x_i, y_i) moving in dir_i,
// returns whether the move leaves the screen (oob_o) and the wall-map address
// of probe k_i on the pixel row/column just ahead of the leading edge.
// Ports: x_i[10], y_i[9], dir_i[2], k_i[K_W] in; oob_o, addr_o[ADDR_W] out.
module maze_probe_addr
  import ghost_pkg::*;
(
  input  logic [9:0]        x_i,
  input  logic [8:0]        y_i,
  input  logic [1:0]        dir_i,
  input  logic [K_W-1:0]    k_i,
  output logic              oob_o,
  output logic [ADDR_W-1:0] addr_o
);

  logic [10:0] x_w, y_w, off, px, py;

  // 11-bit intermediates so x+SPRITE / y+SPRITE never wrap before comparing.
  always_comb begin
    x_w   = {1'b0, x_i};
    y_w   = {2'b0, y_i};
    off   = probe_off(k_i);
    px    = x_w + off;
    py    = y_w - 11'd1;
    oob_o = 1'b0;
    case (dir_i)
      DIR_UP: begin
        px    = x_w + off;
        py    = y_w - 11'd1;
        oob_o = (y_w == 11'd0);
      end
      DIR_DOWN: begin
        px    = x_w + off;
        py    = y_w + 11'(SPRITE);
        oob_o = (py >= 11'(SCR_H));
      end
      DIR_LEFT: begin
        px    = x_w - 11'd1;
        py    = y_w + off;
        oob_o = (x_w == 11'd0);
      end
      default: begin
        px    = x_w + 11'(SPRITE);
        py    = y_w + off;
        oob_o = (px >= 11'(SCR_W));
      end
    endcase
    addr_o = ADDR_W'(py >> CELL_SHIFT) * ADDR_W'(MAP_W) + ADDR_W'(px >> CELL_SHIFT);
  end

endmodule

// File: rtl/maze_wall_probe.sv
// Wall-collision responder for sprite movers. Accepts one probe request at a
// time, checks screen bounds, then walks the leading-edge probes through the
// wall map (one address cycle + one read cycle each), stopping at the first
// wall. Answers with a one-cycle resp_valid and a held resp_clear.
// Ports: clk, rst (sync, active-low); bus = maze_wall_probe_if.slave
// (request/response handshake and wall-map read port).
module maze_wall_probe
  import ghost_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  maze_wall_probe_if.slave bus
);

  probe_state_e      state_q, state_d;
  logic [9:0]        x_q, x_d;
  logic [8:0]        y_q, y_d;
  logic [1:0]        dir_q, dir_d;
  logic [K_W-1:0]    k_q, k_d;
  logic              hit_q, hit_d;
  logic              clear_q, clear_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  logic              oob;
  logic [ADDR_W-1:0] probe_addr;

  maze_probe_addr u_addr (
    .x_i    (x_q),
    .y_i    (y_q),
    .dir_i  (dir_q),
    .k_i    (k_q),
    .oob_o  (oob),
    .addr_o (probe_addr)
  );

  always_comb begin
    state_d        = state_q;
    x_d            = x_q;
    y_d            = y_q;
    dir_d          = dir_q;
    k_d            = k_q;
    hit_d          = hit_q;
    clear_d        = clear_q;
    addr_d         = addr_q;
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.resp_clear = clear_q;
    bus.wall_addr  = addr_q;

    case (state_q)
      ST_IDLE: bus.req_ready = 1'b1;
      ST_BOUND: begin
        if (oob) begin
          bus.resp_valid = 1'b1;
          bus.resp_clear = 1'b0;
          clear_d        = 1'b0;
          bus.req_ready  = 1'b1;
          state_d        = ST_IDLE;
        end else begin
          // Probe 0 is issued straight from the bounds cycle.
          bus.wall_addr = probe_addr;
          addr_d        = probe_addr;
          state_d       = ST_READ;
        end
      end
      ST_READ: begin
        hit_d   = bus.wall_data;
        k_d     = k_q + K_W'(1);
        state_d = ST_ADDR;
      end
      ST_ADDR: begin
        // The address slot after a read doubles as the response slot.
        if (hit_q || (k_q == K_W'(NPROBE))) begin
          bus.resp_valid = 1'b1;
          bus.resp_clear = ~hit_q;
          clear_d        = ~hit_q;
          bus.req_ready  = 1'b1;
          state_d        = ST_IDLE;
        end else begin
          bus.wall_addr = probe_addr;
          addr_d        = probe_addr;
          state_d       = ST_READ;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Ready is also high in the response cycle, so a waiting request is
    // taken back-to-back.
    if (bus.req_ready && bus.req_valid) begin
      x_d     = bus.req_x;
      y_d     = bus.req_y;
      dir_d   = bus.req_dir;
      k_d     = '0;
      hit_d   = 1'b0;
      state_d = ST_BOUND;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      clear_q <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      clear_q <= clear_d;
      addr_q  <= addr_d;
    end
    x_q   <= x_d;
    y_q   <= y_d;
    dir_q <= dir_d;
    k_q   <= k_d;
    hit_q <= hit_d;
  end

endmodule
